slice_serial_logic_unit: RTL and testbench

//   Multi-cycle bitwise logic unit for the datapath. Processes two WIDTH-bit

---
 rtl/slice_serial_logic_unit.sv | 134 +++++++++++++
 tb/tb_slice_serial_logic_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/slice_serial_logic_unit.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR over WIDTH-bit operands,
// one SLICE-bit slice per clock (LSB slice first), with a start/busy/done handshake.
// The registered result and zero flag feed the ALU result mux.
module slice_serial_logic_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Output,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SLICE-1:0] slice_a, slice_b, slice_res;
    logic             last;

    // State, operand/partial-result and output registers; reset abandons any in-flight op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            part_q  <= '0;
            out_q   <= '0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            part_q  <= part_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; operands shift right so the active slice is always at the LSBs,
    // and result slices enter from the top so slice k ends at bits [k*SLICE +: SLICE].
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        part_d    = part_q;
        out_d     = out_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        slice_a   = a_q[SLICE-1:0];
        slice_b   = b_q[SLICE-1:0];
        slice_res = '0;
        last      = (cnt_q == CW'(N - 1));

        case (op_q)
            OP_AND:  slice_res = slice_a & slice_b;
            OP_OR:   slice_res = slice_a | slice_b;
            OP_XOR:  slice_res = slice_a ^ slice_b;
            OP_NOR:  slice_res = ~(slice_a | slice_b);
            default: slice_res = '0;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = input1;
                    b_d     = input2;
                    op_d    = op;
                    part_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d    = a_q >> SLICE;
                b_d    = b_q >> SLICE;
                part_d = (part_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
                cnt_d  = cnt_q + 1'b1;
                if (last) begin
                    out_d   = part_d;
                    zero_d  = (part_d == '0);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Output = out_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_slice_serial_logic_unit.sv
// Self-checking bench for slice_serial_logic_unit in three geometries:
// d0 = 32/4 (N=8), d1 = 32/32 (N=1), d2 = 16/8 (N=2).
module tb_slice_serial_logic_unit;

    logic        clk;
    logic        reset;
    logic [2:0]  start;
    logic [1:0]  op;
    logic [31:0] in1, in2;
    logic [2:0]  busy, done, zero;
    logic [31:0] out0, out1;
    logic [15:0] out2;

    int total = 0;
    int bad   = 0;
    logic [31:0] prev_out [3];

    slice_serial_logic_unit #(.WIDTH(32), .SLICE(4)) u_d0 (
        .clk(clk), .reset(reset), .start(start[0]), .op(op),
        .input1(in1), .input2(in2),
        .busy(busy[0]), .done(done[0]), .Output(out0), .zero(zero[0])
    );

    slice_serial_logic_unit #(.WIDTH(32), .SLICE(32)) u_d1 (
        .clk(clk), .reset(reset), .start(start[1]), .op(op),
        .input1(in1), .input2(in2),
        .busy(busy[1]), .done(done[1]), .Output(out1), .zero(zero[1])
    );

    slice_serial_logic_unit #(.WIDTH(16), .SLICE(8)) u_d2 (
        .clk(clk), .reset(reset), .start(start[2]), .op(op),
        .input1(in1[15:0]), .input2(in2[15:0]),
        .busy(busy[2]), .done(done[2]), .Output(out2), .zero(zero[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_of(input int d);
        case (d)
            0:       return out0;
            1:       return out1;
            default: return {16'h0, out2};
        endcase
    endfunction

    function automatic int n_of(input int d);
        case (d)
            0:       return 8;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    // Reference: whole-word logic op, masked to the unit's width.
    function automatic logic [31:0] model(input int d, input logic [1:0] o,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (o)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a | b);
        endcase
        if (d == 2) r = r & 32'h0000_FFFF;
        return r;
    endfunction

    // Issue one op; returns at the sample point of the cycle where done is high.
    task automatic run_op(input int d, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int pulse_at);
        int cyc;
        bit busy_ok, held;
        op = o; in1 = a; in2 = b;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        cyc = 0; busy_ok = 1'b1; held = 1'b1;
        while (done[d] !== 1'b1 && cyc < 100) begin
            if (busy[d] !== 1'b1) busy_ok = 1'b0;
            if (out_of(d) !== prev_out[d]) held = 1'b0;
            op  = 2'($urandom);
            in1 = $urandom;
            in2 = $urandom;
            if (cyc == pulse_at) begin
                start[d] = 1'b1;
                op = 2'b01;
            end else begin
                start[d] = 1'b0;
            end
            cyc++;
            @(posedge clk); #1;
        end
        start[d] = 1'b0;
        chk($sformatf("d%0d latency", d), 32'(cyc), 32'(n_of(d)));
        chk($sformatf("d%0d busy_run", d), {31'h0, busy_ok}, 32'h1);
        chk($sformatf("d%0d out_hold", d), {31'h0, held}, 32'h1);
        chk($sformatf("d%0d busy_at_done", d), {31'h0, busy[d]}, 32'h0);
        chk($sformatf("d%0d result", d), out_of(d), exp);
        chk($sformatf("d%0d zero", d), {31'h0, zero[d]}, {31'h0, exp == 32'h0});
        prev_out[d] = exp;
    endtask

    // After a done, the unit must sit idle with done low and Output unchanged.
    task automatic idle_check(input int d, input int cycles);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done[d] !== 1'b0 || busy[d] !== 1'b0 || out_of(d) !== prev_out[d]) ok = 1'b0;
        end
        chk($sformatf("d%0d idle_after_done", d), {31'h0, ok}, 32'h1);
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s d%0d busy", tag, d), {31'h0, busy[d]}, 32'h0);
            chk($sformatf("%s d%0d done", tag, d), {31'h0, done[d]}, 32'h0);
            chk($sformatf("%s d%0d out", tag, d), out_of(d), 32'h0);
            chk($sformatf("%s d%0d zero", tag, d), {31'h0, zero[d]}, 32'h1);
            prev_out[d] = 32'h0;
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          nodone;
        int          rd;

        reset = 1'b1;
        start = 3'b000;
        op    = 2'b00;
        in1   = 32'h0;
        in2   = 32'h0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single XOR in every geometry.
        run_op(0, 2'b10, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, -1);
        idle_check(0, 3);
        run_op(1, 2'b10, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, -1);
        idle_check(1, 3);
        run_op(2, 2'b10, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0000_EDCB, -1);
        idle_check(2, 3);

        // All four ops on one operand pair.
        run_op(0, 2'b00, 32'hA5A5_A5A5, 32'h0F0F_F0F0, 32'h0505_A0A0, -1);
        idle_check(0, 1);
        run_op(0, 2'b01, 32'hA5A5_A5A5, 32'h0F0F_F0F0, 32'hAFAF_F5F5, -1);
        idle_check(0, 1);
        run_op(0, 2'b10, 32'hA5A5_A5A5, 32'h0F0F_F0F0, 32'hAAAA_5555, -1);
        idle_check(0, 1);
        run_op(0, 2'b11, 32'hA5A5_A5A5, 32'h0F0F_F0F0, 32'h5050_0A0A, -1);
        idle_check(0, 1);

        // Zero flag, held across idle cycles, in every geometry.
        for (int d = 0; d < 3; d++) begin
            run_op(d, 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, -1);
            idle_check(d, 4);
        end

        // Start pulse plus op/operand changes mid-run are ignored; exactly one done.
        run_op(0, 2'b00, 32'h1234_5678, 32'hFFFF_0000, 32'h1234_0000, 3);
        idle_check(0, 10);

        // Back-to-back: second start lands in the done cycle.
        run_op(0, 2'b01, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, -1);
        run_op(0, 2'b11, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, -1);
        idle_check(0, 2);
        run_op(2, 2'b00, 32'h0000_F00F, 32'h0000_FF00, 32'h0000_F000, -1);
        run_op(2, 2'b11, 32'h0000_0F0F, 32'h0000_00F0, 32'h0000_F000, -1);
        idle_check(2, 2);

        // Asynchronous reset in the middle of a run.
        op = 2'b01; in1 = 32'h1111_1111; in2 = 32'h2222_2222;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        check_reset_state("midrun_reset");
        #2 reset = 1'b0;
        nodone = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) nodone = 1'b0;
        end
        chk("no_done_after_reset", {31'h0, nodone}, 32'h1);
        run_op(0, 2'b00, 32'hCAFE_BABE, 32'hFFFF_FFFF, 32'hCAFE_BABE, -1);
        idle_check(0, 1);

        // Randomized ops against the reference model.
        for (int t = 0; t < 40; t++) begin
            rd = int'($urandom_range(0, 2));
            ro = 2'($urandom);
            ra = $urandom;
            rb = (t % 7 == 0) ? ra : $urandom;
            run_op(rd, ro, ra, rb, model(rd, ro, ra, rb), -1);
            if ($urandom_range(0, 1) == 0) begin
                run_op(rd, ~ro, rb, ra, model(rd, ~ro, rb, ra), -1);
            end
            idle_check(rd, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
